// File: rtl/dsp_mac_pipe.sv
// Parametrised pre-add / multiply / post-add slice with B and P cascade.
// Define DSP_SAT_EN for unsigned saturation of the post-adder result.
module dsp_mac_pipe #(
    parameter int AW     = 18,
    parameter int BW     = 18,
    parameter int PW     = 48,
    parameter int IREG   = 1,
    parameter int PREREG = 1,
    parameter int MREG   = 1,
    parameter int PREG   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             IN_VALID,
    input  logic [AW-1:0]    A,
    input  logic [BW-1:0]    B,
    input  logic [BW-1:0]    BCIN,
    input  logic [BW-1:0]    D,
    input  logic [PW-1:0]    C,
    input  logic [PW-1:0]    PCIN,
    input  logic             CARRYIN,
    input  logic [7:0]       OPMODE,
    input  logic             B_SEL,
    output logic [AW+BW-1:0] M,
    output logic [PW-1:0]    P,
    output logic [PW-1:0]    PCOUT,
    output logic [BW-1:0]    BCOUT,
    output logic             CARRYOUT,
    output logic             CARRYOUTF,
    output logic             OUT_VALID
);

    typedef struct packed {
        logic          vld;
        logic [7:0]    op;
        logic          cin;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] d;
        logic [PW-1:0] c;
    } in_t;

    typedef struct packed {
        logic          vld;
        logic [7:0]    op;
        logic          cin;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] d;
        logic [PW-1:0] c;
        logic [BW-1:0] pre;
    } pa_t;

    typedef struct packed {
        logic             vld;
        logic [7:0]       op;
        logic             cin;
        logic [AW-1:0]    a;
        logic [BW-1:0]    b;
        logic [BW-1:0]    d;
        logic [PW-1:0]    c;
        logic [AW+BW-1:0] m;
    } mu_t;

    in_t in_d, in_s;
    pa_t pa_d, pa_s;
    mu_t mu_d, mu_s;

    always_comb begin
        in_d.vld = IN_VALID;
        in_d.op  = OPMODE;
        in_d.cin = CARRYIN;
        in_d.a   = A;
        in_d.b   = B_SEL ? BCIN : B;
        in_d.d   = D;
        in_d.c   = C;
    end

    if (IREG != 0) begin : g_ireg
        in_t in_q;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                in_q <= '0;
            end else if (CE) begin
                in_q <= in_d;
            end
        end
        assign in_s = in_q;
    end else begin : g_noireg
        assign in_s = in_d;
    end

    // Pre-adder wraps modulo 2^BW; its carry is intentionally dropped.
    always_comb begin
        pa_d.vld = in_s.vld;
        pa_d.op  = in_s.op;
        pa_d.cin = in_s.cin;
        pa_d.a   = in_s.a;
        pa_d.b   = in_s.b;
        pa_d.d   = in_s.d;
        pa_d.c   = in_s.c;
        if (!in_s.op[4]) begin
            pa_d.pre = in_s.b;
        end else if (in_s.op[6]) begin
            pa_d.pre = in_s.d - in_s.b;
        end else begin
            pa_d.pre = in_s.d + in_s.b;
        end
    end

    if (PREREG != 0) begin : g_prereg
        pa_t pa_q;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                pa_q <= '0;
            end else if (CE) begin
                pa_q <= pa_d;
            end
        end
        assign pa_s = pa_q;
    end else begin : g_noprereg
        assign pa_s = pa_d;
    end

    always_comb begin
        mu_d.vld = pa_s.vld;
        mu_d.op  = pa_s.op;
        mu_d.cin = pa_s.cin;
        mu_d.a   = pa_s.a;
        mu_d.b   = pa_s.b;
        mu_d.d   = pa_s.d;
        mu_d.c   = pa_s.c;
        mu_d.m   = (AW+BW)'(pa_s.a) * (AW+BW)'(pa_s.pre);
    end

    if (MREG != 0) begin : g_mreg
        mu_t mu_q;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                mu_q <= '0;
            end else if (CE) begin
                mu_q <= mu_d;
            end
        end
        assign mu_s = mu_q;
    end else begin : g_nomreg
        assign mu_s = mu_d;
    end

    logic [PW-1:0] p_fb;
    logic [PW-1:0] x_op;
    logic [PW-1:0] z_op;
    logic [PW-1:0] p_d;
    logic [PW-1:0] p_s;
    logic [PW:0]   xc;
    logic [PW:0]   r;
    logic          cin_eff;
    logic          co_s;
    logic          vld_s;

    always_comb begin
        case (mu_s.op[1:0])
            2'd0:    x_op = '0;
            2'd1:    x_op = PW'(mu_s.m);
            2'd2:    x_op = p_fb;
            default: x_op = PW'({mu_s.d, mu_s.a, mu_s.b});
        endcase
    end

    always_comb begin
        case (mu_s.op[3:2])
            2'd0:    z_op = '0;
            2'd1:    z_op = PCIN;
            2'd2:    z_op = p_fb;
            default: z_op = mu_s.c;
        endcase
    end

    // Subtract takes X+CIN as one PW+1 bit subtrahend so R[PW] is the borrow.
    always_comb begin
        cin_eff = mu_s.op[5] & mu_s.cin;
        xc      = {1'b0, x_op} + {{PW{1'b0}}, cin_eff};
        if (mu_s.op[7]) begin
            r = {1'b0, z_op} - xc;
        end else begin
            r = {1'b0, z_op} + xc;
        end
`ifdef DSP_SAT_EN
        if (r[PW]) begin
            p_d = mu_s.op[7] ? '0 : '1;
        end else begin
            p_d = r[PW-1:0];
        end
`else
        p_d = r[PW-1:0];
`endif
    end

    if (PREG != 0) begin : g_preg
        logic [PW-1:0] p_q;
        logic          co_q;
        logic          vld_q;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                p_q   <= '0;
                co_q  <= 1'b0;
                vld_q <= 1'b0;
            end else if (CE) begin
                p_q   <= p_d;
                co_q  <= r[PW];
                vld_q <= mu_s.vld;
            end
        end
        assign p_s   = p_q;
        assign co_s  = co_q;
        assign vld_s = vld_q;
        assign p_fb  = p_q;
    end else begin : g_nopreg
        // No register to feed back from, so P selections read as zero.
        assign p_s   = p_d;
        assign co_s  = r[PW];
        assign vld_s = mu_s.vld;
        assign p_fb  = '0;
    end

    logic unused_bits;
    assign unused_bits = ^{mu_s.op[6], mu_s.op[4], mu_s.d};

    assign M         = mu_s.m;
    assign P         = p_s;
    assign PCOUT     = p_s;
    assign BCOUT     = pa_s.b;
    assign CARRYOUT  = co_s;
    assign CARRYOUTF = co_s;
    assign OUT_VALID = vld_s;

endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
Parametrised multiply-accumulate slice with pre-adder, multiplier, post-adder/accumulator and cascade ports. It generalises the fixed 18x18/48 slice: data widths are set by parameters, and each pipeline stage can be kept or bypassed. OPMODE travels down the pipeline with its sample, and a valid pipe marks result cycles. It sits in the datapath as the arithmetic core for filters and accumulators. Slices chain through BCOUT/PCOUT.

Parameters:
AW, 18, width of A
BW, 18, width of B, D, BCIN, BCOUT
PW, 48, width of C, PCIN, P, PCOUT; must be >= AW+BW
IREG, 1, input register stage on A/B/D/C/CARRYIN/OPMODE (0 = bypass)
PREREG, 1, register after pre-adder (A1/B1 stage)
MREG, 1, multiplier output register
PREG, 1, post-adder output register (P, CARRYOUT)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset, all state to 0
CE  in  1  global clock enable; low freezes every register, including the valid pipe
IN_VALID  in  1  sample qualifier
A  in  AW  multiplier operand
B  in  BW  pre-adder operand
BCIN  in  BW  cascaded B input
D  in  BW  pre-adder operand
C  in  PW  post-adder operand
PCIN  in  PW  cascaded P input
CARRYIN  in  1  post-adder carry
OPMODE  in  8  per-sample mode
B_SEL  in  1  1 = use BCIN instead of B
M  out  AW+BW  multiplier result (after MREG if enabled)
P  out  PW  post-adder result
PCOUT  out  PW  equals P
BCOUT  out  BW  B operand after the pre-adder stage
CARRYOUT  out  1  post-adder carry/borrow bit
CARRYOUTF  out  1  copy of CARRYOUT
OUT_VALID  out  1  P/CARRYOUT hold a valid sample

Behaviour:
- Reset is asynchronous and active-high. RST=1 immediately clears all registers, including the staged OPMODE and the valid pipe, so every output reads 0. The first sample after release starts a fresh pipeline; in-flight samples are discarded.
- Latency L = IREG+PREREG+MREG+PREG (range 0..4). OUT_VALID is IN_VALID delayed by L enabled cycles. With L=0 the slice is fully combinational.
- Each sample carries its own OPMODE and CARRYIN through every enabled stage. A mode change takes effect only on that sample and never corrupts samples already in flight.
- The valid pipe is a qualifier only: the datapath advances whenever CE=1, regardless of IN_VALID.
- Pre-adder, OPMODE[4]=1:
  - pre = D-B if OPMODE[6]=1, else D+B.
  - Result is BW bits, modulo 2^BW, unsigned; the carry is dropped.
  - OPMODE[4]=0: pre = B.
  - B is BCIN when B_SEL=1.
- BCOUT = pre-adder-stage B value.
- Multiplier: M = A * pre, unsigned, full AW+BW bits, no truncation.
- X mux, OPMODE[1:0]:
  - 0: 0
  - 1: M zero-extended to PW
  - 2: P (feedback)
  - 3: {D,A,B} concatenation, zero-extended or truncated to PW (LSBs kept)
- Z mux, OPMODE[3:2]:
  - 0: 0
  - 1: PCIN
  - 2: P (feedback)
  - 3: C
- Post-adder:
  - OPMODE[7]=0: R = Z + X + CIN.
  - OPMODE[7]=1: R = Z - (X + CIN).
  - CIN = CARRYIN if OPMODE[5]=1, else 0.
  - R is computed at PW+1 bits. P = R[PW-1:0], CARRYOUT = R[PW]; P wraps modulo 2^PW.
- P feedback with PREG=0 is illegal as a loop. Selecting P in either mux then yields 0 for that operand.
- Accumulate: X=M and Z=P with PREG=1 adds one product per enabled cycle.
- Simultaneous RST and CE: RST wins.
- CE low for any number of cycles, then high: the pipeline resumes with contents intact.

Optional Feature:
DSP_SAT_EN
- Defined: post-adder saturates on unsigned overflow.
  - Add with R[PW]=1 gives P = all ones.
  - Subtract with borrow gives P = 0.
  - CARRYOUT still reports the raw R[PW].
- Undefined: P wraps as described above; no saturation logic is synthesised.

Test Plan:
1. Defaults, OPMODE=0x11 (pre-add, X=M, Z=0), D=3, B=4, A=5, IN_VALID=1 for one cycle -> P=35 and OUT_VALID=1 exactly 4 cycles later, 0 otherwise.
2. OPMODE=0x51 (pre-subtract), D=2, B=5 -> pre=2^18-3; M=A*(262141) with A=1 -> M=262141, P=262141.
3. Accumulate OPMODE=0x09 (X=M, Z=P), A=2, B=3 for 5 cycles after a flush -> P steps 6,12,18,24,30; then OPMODE=0x89 (subtract) for one sample -> P=24.
4. C=2^48-1, OPMODE=0x2C (Z=C, X=0, CIN=1), CARRYIN=1 -> P=0, CARRYOUT=1; with DSP_SAT_EN -> P=2^48-1, CARRYOUT=1.
5. Assert RST asynchronously mid-stream with 3 samples in flight -> P, M, BCOUT, OUT_VALID = 0 before the next edge; no stale OUT_VALID after release.
6. All *REG=0, B_SEL=1, BCIN=7, A=6, OPMODE=0x01 -> P=42, BCOUT=7, OUT_VALID=IN_VALID in the same cycle. Then CE=0 with PREG=1 build -> P holds its value for 10 cycles.
